// File: rtl/bbox_overlay.sv
// Avalon-ST stage: finds the bounding box of red pixels in each video frame and outlines it
// on the following frame. Define BBOX_HIGHLIGHT_EN to also paint matching pixels white.
module bbox_overlay #(
    parameter int          IMAGE_W    = 640,
    parameter int          IMAGE_H    = 480,
    parameter logic [7:0]  R_MIN      = 8'd160,
    parameter logic [7:0]  GB_MAX     = 8'd80,
    parameter logic [23:0] BOX_COLOUR = 24'hFF0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] sink_data,
    input  logic        sink_valid,
    input  logic        sink_sop,
    input  logic        sink_eop,
    output logic        sink_ready,
    output logic [23:0] source_data,
    output logic        source_valid,
    output logic        source_sop,
    output logic        source_eop,
    input  logic        source_ready,
    output logic        box_valid
);
    localparam int XW = $clog2(IMAGE_W);
    localparam int YW = $clog2(IMAGE_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMAGE_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_H - 1);

    logic [23:0]   source_data_q, source_data_d;
    logic          source_valid_q, source_valid_d;
    logic          source_sop_q, source_sop_d;
    logic          source_eop_q, source_eop_d;
    logic          box_valid_q, box_valid_d;
    logic          in_video_q, in_video_d;
    logic          hit_q, hit_d;
    logic [XW-1:0] x_q, x_d, xmin_q, xmin_d, xmax_q, xmax_d, l_q, l_d, r_q, r_d;
    logic [YW-1:0] y_q, y_d, ymin_q, ymin_d, ymax_q, ymax_d, t_q, t_d, b_q, b_d;

    logic          xfer;
    logic          is_pixel;
    logic          match;
    logic          on_box;
    logic [23:0]   pixel_out;

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        sink_ready     = ~source_valid_q | source_ready;
        xfer           = sink_valid & sink_ready;
        is_pixel       = xfer & ~sink_sop & in_video_q;
        match          = is_pixel && (sink_data[23:16] >= R_MIN) &&
                         (sink_data[15:8] <= GB_MAX) && (sink_data[7:0] <= GB_MAX);
        on_box         = box_valid_q &&
                         (((x_q == l_q || x_q == r_q) && y_q >= t_q && y_q <= b_q) ||
                          ((y_q == t_q || y_q == b_q) && x_q >= l_q && x_q <= r_q));

        pixel_out = sink_data;
`ifdef BBOX_HIGHLIGHT_EN
        if (match) pixel_out = 24'hFFFFFF;
`endif
        if (on_box) pixel_out = BOX_COLOUR;

        source_data_d  = source_data_q;
        source_valid_d = source_valid_q;
        source_sop_d   = source_sop_q;
        source_eop_d   = source_eop_q;
        box_valid_d    = box_valid_q;
        in_video_d     = in_video_q;
        hit_d          = hit_q;
        x_d            = x_q;
        y_d            = y_q;
        xmin_d         = xmin_q;
        xmax_d         = xmax_q;
        ymin_d         = ymin_q;
        ymax_d         = ymax_q;
        l_d            = l_q;
        r_d            = r_q;
        t_d            = t_q;
        b_d            = b_q;

        // The output register reloads whenever it is empty or being drained this cycle.
        if (sink_ready) begin
            source_valid_d = sink_valid;
            if (sink_valid) begin
                source_data_d = is_pixel ? pixel_out : sink_data;
                source_sop_d  = sink_sop;
                source_eop_d  = sink_eop;
            end
        end

        if (xfer && sink_sop) begin
            in_video_d = (sink_data[3:0] == 4'd0);
            if (sink_data[3:0] == 4'd0) begin
                x_d    = '0;
                y_d    = '0;
                xmin_d = X_LAST;
                xmax_d = '0;
                ymin_d = Y_LAST;
                ymax_d = '0;
                hit_d  = 1'b0;
            end
        end else if (is_pixel) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q != Y_LAST) y_d = y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
            if (match) begin
                if (x_q < xmin_q) xmin_d = x_q;
                if (x_q > xmax_q) xmax_d = x_q;
                if (y_q < ymin_q) ymin_d = y_q;
                if (y_q > ymax_q) ymax_d = y_q;
                hit_d = 1'b1;
            end
            // Frame end latches the box including this final pixel's own update.
            if (sink_eop) begin
                l_d         = xmin_d;
                r_d         = xmax_d;
                t_d         = ymin_d;
                b_d         = ymax_d;
                box_valid_d = hit_d;
            end
        end

        if (xfer && sink_eop) in_video_d = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            source_data_q  <= '0;
            source_valid_q <= 1'b0;
            source_sop_q   <= 1'b0;
            source_eop_q   <= 1'b0;
            box_valid_q    <= 1'b0;
            in_video_q     <= 1'b0;
            hit_q          <= 1'b0;
            x_q            <= '0;
            y_q            <= '0;
            xmin_q         <= '0;
            xmax_q         <= '0;
            ymin_q         <= '0;
            ymax_q         <= '0;
            l_q            <= '0;
            r_q            <= '0;
            t_q            <= '0;
            b_q            <= '0;
        end else begin
            source_data_q  <= source_data_d;
            source_valid_q <= source_valid_d;
            source_sop_q   <= source_sop_d;
            source_eop_q   <= source_eop_d;
            box_valid_q    <= box_valid_d;
            in_video_q     <= in_video_d;
            hit_q          <= hit_d;
            x_q            <= x_d;
            y_q            <= y_d;
            xmin_q         <= xmin_d;
            xmax_q         <= xmax_d;
            ymin_q         <= ymin_d;
            ymax_q         <= ymax_d;
            l_q            <= l_d;
            r_q            <= r_d;
            t_q            <= t_d;
            b_q            <= b_d;
        end
    end

    assign source_data  = source_data_q;
    assign source_valid = source_valid_q;
    assign source_sop   = source_sop_q;
    assign source_eop   = source_eop_q;
    assign box_valid    = box_valid_q;

endmodule

// File: tb/tb_bbox_overlay.sv
// Directed bench for bbox_overlay on a 4x2 frame: pass-through, box latch/outline,
// control packets, short/long frames, random stalls and mid-frame reset.
module tb_bbox_overlay;
    localparam int          W    = 4;
    localparam int          H    = 2;
    localparam logic [23:0] BOX  = 24'hFF0000;
    localparam logic [23:0] RED  = 24'hFF0000;
    localparam logic [23:0] GREY = 24'h808080;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] sink_data;
    logic        sink_valid, sink_sop, sink_eop, sink_ready;
    logic [23:0] source_data;
    logic        source_valid, source_sop, source_eop, source_ready;
    logic        box_valid;

    int checks   = 0;
    int failures = 0;
    bit rand_valid = 1'b0;
    bit rand_ready = 1'b0;

    logic [25:0] got_q[$];
    logic [25:0] exp_q[$];
    logic [23:0] px[0:11];

    // Expected display box carried from one frame to the next.
    bit m_box = 1'b0;
    int m_l, m_r, m_t, m_b;

    bbox_overlay #(
        .IMAGE_W(W), .IMAGE_H(H), .R_MIN(8'd160), .GB_MAX(8'd80), .BOX_COLOUR(BOX)
    ) dut (
        .clk(clk), .reset(reset),
        .sink_data(sink_data), .sink_valid(sink_valid), .sink_sop(sink_sop),
        .sink_eop(sink_eop), .sink_ready(sink_ready),
        .source_data(source_data), .source_valid(source_valid), .source_sop(source_sop),
        .source_eop(source_eop), .source_ready(source_ready),
        .box_valid(box_valid)
    );

    always #5 clk = ~clk;

    initial begin
        source_ready = 1'b1;
        forever begin
            @(negedge clk);
            source_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (source_valid && source_ready) got_q.push_back({source_sop, source_eop, source_data});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_red(input logic [23:0] p);
        return p[23:16] >= 8'd160 && p[15:8] <= 8'd80 && p[7:0] <= 8'd80;
    endfunction

    task automatic send_beat(input logic [23:0] d, input logic s, input logic e);
        int guard = 0;
        @(negedge clk);
        if (rand_valid) begin
            while ($urandom_range(0, 1) == 0) begin
                sink_valid = 1'b0;
                @(negedge clk);
            end
        end
        sink_valid = 1'b1;
        sink_data  = d;
        sink_sop   = s;
        sink_eop   = e;
        forever begin
            #2;
            if (sink_ready) break;
            guard++;
            if (guard > 2000) begin
                check("send_ready", 32'(sink_ready), 32'd1);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        sink_valid = 1'b0;
    endtask

    // Sends header plus n pixels from px[] and queues the expected output beats.
    task automatic send_video(input int n);
        int lo_x, hi_x, lo_y, hi_y, x, y;
        bit hit, on;
        logic [23:0] e;
        lo_x = W - 1; hi_x = 0; lo_y = H - 1; hi_y = 0; hit = 1'b0;
        exp_q.push_back({1'b1, 1'b0, 24'h000000});
        send_beat(24'h000000, 1'b1, 1'b0);
        for (int i = 0; i < n; i++) begin
            x = i % W;
            y = (i / W > H - 1) ? H - 1 : i / W;
            on = m_box && (((x == m_l || x == m_r) && y >= m_t && y <= m_b) ||
                           ((y == m_t || y == m_b) && x >= m_l && x <= m_r));
            e = px[i];
`ifdef BBOX_HIGHLIGHT_EN
            if (is_red(px[i])) e = 24'hFFFFFF;
`endif
            if (on) e = BOX;
            if (is_red(px[i])) begin
                if (x < lo_x) lo_x = x;
                if (x > hi_x) hi_x = x;
                if (y < lo_y) lo_y = y;
                if (y > hi_y) hi_y = y;
                hit = 1'b1;
            end
            exp_q.push_back({1'b0, (i == n - 1), e});
            send_beat(px[i], 1'b0, (i == n - 1));
        end
        m_box = hit; m_l = lo_x; m_r = hi_x; m_t = lo_y; m_b = hi_y;
    endtask

    task automatic send_ctrl();
        exp_q.push_back({1'b1, 1'b0, 24'hABC00F});
        send_beat(24'hABC00F, 1'b1, 1'b0);
        exp_q.push_back({1'b0, 1'b0, 24'h123456});
        send_beat(24'h123456, 1'b0, 1'b0);
        exp_q.push_back({1'b0, 1'b1, 24'h654321});
        send_beat(24'h654321, 1'b0, 1'b1);
    endtask

    task automatic fill(input logic [23:0] p);
        for (int i = 0; i < 12; i++) px[i] = p;
    endtask

    task automatic wait_out();
        int guard = 0;
        while (got_q.size() < exp_q.size() && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic compare(input string tag);
        check($sformatf("%s_count", tag), got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_px(input string tag, input int beat, input logic [23:0] exp);
        logic [23:0] obs = 24'hxxxxxx;
        if (beat < got_q.size()) obs = got_q[beat][23:0];
        check(tag, 32'(obs), 32'(exp));
    endtask

    initial begin
        reset = 1'b1; sink_valid = 1'b0; sink_data = '0; sink_sop = 1'b0; sink_eop = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_valid", 32'(source_valid), 32'd0);
        check("rst_sop", 32'(source_sop), 32'd0);
        check("rst_eop", 32'(source_eop), 32'd0);
        check("rst_data", 32'(source_data), 32'd0);
        check("rst_box_valid", 32'(box_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Stray eop before any sop: passes through, 1-cycle latency, no latch.
        exp_q.push_back({1'b0, 1'b1, RED});
        send_beat(RED, 1'b0, 1'b1);
        idle();
        #2;
        check("lat_valid", 32'(source_valid), 32'd1);
        check("lat_data", 32'(source_data), 32'(RED));
        check("lat_eop", 32'(source_eop), 32'd1);
        @(negedge clk);
        #2;
        check("lat_idle", 32'(source_valid), 32'd0);
        check("stray_box_valid", 32'(box_valid), 32'd0);
        wait_out();
        compare("stray");

        // No matches, including near misses on each threshold.
        px[0] = 24'h9F0000; px[1] = 24'hA05100; px[2] = 24'hA00051; px[3] = 24'h102030;
        px[4] = GREY;       px[5] = 24'hFFFFFF; px[6] = 24'h000000; px[7] = 24'h7F1010;
        send_video(8);
        idle();
        wait_out();
        check_px("nomatch_px0", 1, 24'h9F0000);
        check_px("nomatch_px7", 8, 24'h7F1010);
        check("nomatch_box_valid", 32'(box_valid), 32'd0);
        compare("nomatch");

        // Single red pixel at (2,1), then a grey frame outlined only there.
        fill(GREY); px[6] = RED;
        send_video(8);
        idle();
        wait_out();
        check("one_box_valid", 32'(box_valid), 32'd1);
        compare("one_red");
        fill(GREY);
        send_video(8);
        idle();
        wait_out();
        check_px("one_out_21", 7, BOX);
        check_px("one_out_11", 6, GREY);
        check_px("one_out_20", 3, GREY);
        check("one_after_grey_box_valid", 32'(box_valid), 32'd0);
        compare("one_grey");

        // Corners (0,0) at exact thresholds and (3,1) on the final pixel; control packet in between.
        fill(GREY); px[0] = 24'hA05050; px[7] = RED;
        send_video(8);
        send_ctrl();
        idle();
        wait_out();
        check("corner_box_valid", 32'(box_valid), 32'd1);
        check("ctrl_sop", 32'(got_q.size() > 9 ? got_q[9] : 26'h0), 32'({1'b1, 1'b0, 24'hABC00F}));
        compare("corner");
        fill(GREY);
        send_video(8);
        idle();
        wait_out();
        for (int i = 0; i < 8; i++) check_px($sformatf("full_outline_%0d", i), i + 1, BOX);
        compare("full_outline");

        // Short frame latches normally; long frame keeps comparing past saturated y.
        fill(GREY); px[1] = RED;
        send_video(3);
        idle();
        wait_out();
        check("short_box_valid", 32'(box_valid), 32'd1);
        compare("short");
        fill(GREY); px[9] = RED;
        send_video(10);
        idle();
        wait_out();
        check_px("short_box_10", 2, BOX);
        check_px("short_box_11", 6, GREY);
        check("long_box_valid", 32'(box_valid), 32'd1);
        compare("long");
        fill(GREY);
        send_video(8);
        idle();
        wait_out();
        check_px("long_box_11", 6, BOX);
        check_px("long_box_01", 5, GREY);
        compare("after_long");

        // Random valid/ready at 50% over 10 frames.
        rand_valid = 1'b1;
        rand_ready = 1'b1;
        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < 8; i++) begin
                case ($urandom_range(0, 3))
                    0: px[i] = {8'($urandom_range(160, 255)), 8'($urandom_range(0, 80)), 8'($urandom_range(0, 80))};
                    1: px[i] = {8'($urandom_range(0, 159)), 8'($urandom), 8'($urandom)};
                    2: px[i] = 24'($urandom);
                    default: px[i] = 24'hA05051;
                endcase
            end
            send_video(8);
            if (f == 4) send_ctrl();
        end
        idle();
        rand_valid = 1'b0;
        rand_ready = 1'b0;
        wait_out();
        compare("random");

        // Mid-frame reset drops the box; frame 3 passes unboxed.
        fill(GREY); px[1] = RED;
        send_video(8);
        idle();
        wait_out();
        check("pre_rst_box_valid", 32'(box_valid), 32'd1);
        compare("pre_rst");
        send_beat(24'h000000, 1'b1, 1'b0);
        send_beat(GREY, 1'b0, 1'b0);
        send_beat(GREY, 1'b0, 1'b0);
        send_beat(GREY, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        sink_valid = 1'b0;
        #2;
        check("mid_rst_valid", 32'(source_valid), 32'd0);
        check("mid_rst_data", 32'(source_data), 32'd0);
        check("mid_rst_sop", 32'(source_sop), 32'd0);
        check("mid_rst_eop", 32'(source_eop), 32'd0);
        check("mid_rst_box_valid", 32'(box_valid), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        got_q.delete();
        exp_q.delete();
        m_box = 1'b0;
        exp_q.push_back({1'b0, 1'b0, RED});
        send_beat(RED, 1'b0, 1'b0);
        exp_q.push_back({1'b0, 1'b1, RED});
        send_beat(RED, 1'b0, 1'b1);
        idle();
        wait_out();
        check("ignored_box_valid", 32'(box_valid), 32'd0);
        compare("ignored");
        fill(GREY);
        send_video(8);
        idle();
        wait_out();
        check_px("frame3_px1", 2, GREY);
        check_px("frame3_px0", 1, GREY);
        compare("frame3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bbox_overlay.md
# bbox_overlay

Avalon-ST video stage between the camera/frame-buffer path and the `alt_vip_itc` clocked-video output. It detects pixels matching a red colour threshold in each video frame and accumulates their bounding box. It then draws that box's one-pixel outline onto the following frame. Control packets pass through untouched.

## Interface
Parameters:
- `IMAGE_W`, 640: active pixels per line; x counter width is `$clog2(IMAGE_W)`.
- `IMAGE_H`, 480: active lines per frame; y counter width is `$clog2(IMAGE_H)`.
- `R_MIN`, 8'd160: minimum red component for a match.
- `GB_MAX`, 8'd80: maximum green and maximum blue component for a match.
- `BOX_COLOUR`, 24'hFF0000: outline pixel value, packed {R,G,B}.

Ports:
- `clk`, in, 1: sole clock, the video pipeline clock.
- `reset`, in, 1: reset is asynchronous and active-high.
- `sink_data`, in, 24: {R[23:16], G[15:8], B[7:0]}.
- `sink_valid`, in, 1: beat present.
- `sink_sop`, in, 1: start of packet. On this beat, `sink_data[3:0]` is the packet type; 0 means video.
- `sink_eop`, in, 1: end of packet.
- `sink_ready`, out, 1: sink may transfer.
- `source_data`, out, 24: output pixel or header.
- `source_valid`, `source_sop`, `source_eop`, out, 1 each: qualifiers for the output beat.
- `source_ready`, in, 1: downstream accepts.
- `box_valid`, out, 1: a box is latched from the previous frame.

## Operation
- Transfer rule: a sink beat transfers when `sink_valid & sink_ready`; a source beat transfers when `source_valid & source_ready`.
- Packet type:
  - The sop beat sets `in_video` = (`sink_data[3:0]==0`).
  - A video header beat itself is passed through unmodified and is not a pixel.
  - All beats of non-video packets pass unmodified and do not affect counters or accumulators.
- Counters:
  - `x` and `y` clear to 0 on a video sop.
  - Each pixel beat uses the current (x, y), then increments x.
  - When x reaches `IMAGE_W-1`, x wraps to 0 and y increments.
  - y saturates at `IMAGE_H-1`.
- Match: `R>=R_MIN && G<=GB_MAX && B<=GB_MAX`, unsigned 8-bit comparisons.
- Accumulators `xmin`, `xmax`, `ymin`, `ymax`, plus flag `hit`:
  - On video sop they initialise to `IMAGE_W-1`, 0, `IMAGE_H-1`, 0, and `hit`=0.
  - Each matching pixel does a min/max update and sets `hit`.
- Frame end (pixel beat with eop in a video packet, including that beat's own update):
  - Copy the accumulators to display registers `L/R/T/B`.
  - Set `box_valid` = `hit`, counting that final pixel's match.
- Outline: a pixel is on the box when `box_valid` holds and either:
  - (x==L or x==R) and T<=y<=B, or
  - (y==T or y==B) and L<=x<=R.
  - Outline pixels output `BOX_COLOUR`; all other pixels pass unchanged.
- Short frame (eop before `IMAGE_W*IMAGE_H` pixels): latch normally.
- Long frame: pixels beyond the saturated y still pass through and are still compared.
- eop with no preceding sop since reset: beat passes through; no latch.
- A display register update takes effect on the next frame's first pixel, never mid-frame.

## Timing
- Single output register stage; latency is exactly 1 cycle from sink transfer to `source_valid`.
- `sink_ready` = `~source_valid | source_ready`, combinational. No beat is dropped or duplicated under any stall pattern.
- `source_data`, sop and eop hold stable while `source_valid & ~source_ready`.
- Full throughput: 1 pixel per clock when `source_ready` is held at 1.
- Reset values:
  - `source_valid`=0, `source_sop`=0, `source_eop`=0, `source_data`=0, `box_valid`=0.
  - x=y=0, `in_video`=0, `hit`=0, display registers 0.
- Reset mid-frame discards the in-flight beat and box. The stage ignores pixel beats until the next sop.

## Configuration
- `BBOX_HIGHLIGHT_EN` defined: matching pixels in the current frame output 24'hFFFFFF. Outline colour takes priority when both apply.
- Not defined: matching pixels pass unchanged; only the outline is drawn.

## Test plan
- 4x2 frame (`IMAGE_W`=4, `IMAGE_H`=2) with no matches, `source_ready`=1:
  - Output equals input, delayed 1 cycle.
  - `box_valid`=0 after eop.
- Frame 1 with the single red pixel (FF,00,00) at (2,1), then frame 2 all grey (80,80,80):
  - `box_valid`=1.
  - Frame 2 outputs `BOX_COLOUR` only at (2,1).
- Red pixels at (0,0) and (3,1), then frame 2 grey: frame 2 outline covers all 8 pixels of the 4x2 frame.
- Control packet (type 0xF, 3 beats) between frames: beats pass bit-exact, and the box and counters are unchanged.
- Random `source_ready` and `sink_valid` at 50% each over 10 frames: the output sequence matches the reference model with no loss or duplication.
- Assert `reset` mid-frame 2: outputs return to 0, `box_valid`=0, and frame 3 passes unboxed.
